// File: rtl/buffer_window_reader_if.sv
// Buffer read bus plus window output stream between the window reader and its neighbours.
interface buffer_window_reader_if #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned ADR_SIZE  = 10
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [ADR_SIZE-1:0]  bufAdr;
  logic [WORD_SIZE-1:0] bufData;
  logic [WORD_SIZE-1:0] outData;
  logic                 outValid;
  logic                 outReady;
  logic                 outLastWin;
  logic                 outLastImg;

  modport master (
    input  start, bufData, outReady,
    output busy, done, bufAdr, outData, outValid, outLastWin, outLastImg
  );

  modport slave (
    output start, bufData, outReady,
    input  busy, done, bufAdr, outData, outValid, outLastWin, outLastImg
  );
endinterface

// File: rtl/buffer_window_reader.sv
// Streams every KxK window of an IMG_HxIMG_W buffer in row-major order over valid/ready.
// Addresses are built incrementally from window and row base registers.
module buffer_window_reader #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned IMG_W     = 28,
  parameter int unsigned IMG_H     = 28,
  parameter int unsigned K         = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  buffer_window_reader_if.master bus
);
  localparam int unsigned ADR_SIZE = $clog2(IMG_W * IMG_H);
  localparam int unsigned OW       = IMG_W - K + 1;
  localparam int unsigned OH       = IMG_H - K + 1;
  localparam int unsigned XW       = $clog2(OW + 1);
  localparam int unsigned YW       = $clog2(OH + 1);
  localparam int unsigned KW       = $clog2(K + 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [YW-1:0]        r_oy;
  logic [XW-1:0]        r_ox;
  logic [KW-1:0]        r_ky;
  logic [KW-1:0]        r_kx;
  logic [ADR_SIZE-1:0]  r_win_base;
  logic [ADR_SIZE-1:0]  r_row_base;
  logic [WORD_SIZE-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 r_last_win;
  logic                 r_last_img;
  logic                 r_done;
  logic                 w_ld;
  logic                 w_accept;
  logic                 w_busy;
  logic                 w_win_end;
  logic                 w_img_end;
  logic [ADR_SIZE-1:0]  w_adr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.start)            w_state_nxt = S_STREAM;
      S_STREAM: if (w_ld && w_img_end)    w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_accept)             w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = 1'b0;
    w_ld      = 1'b0;
    w_accept  = 1'b0;
    w_win_end = 1'b0;
    w_img_end = 1'b0;
    w_adr     = '0;
    w_busy    = (r_state != S_IDLE);
    w_accept  = r_out_valid && bus.outReady;
    w_ld      = (r_state == S_STREAM) && (!r_out_valid || bus.outReady);
    w_win_end = (r_kx == KW'(K - 1)) && (r_ky == KW'(K - 1));
    w_img_end = w_win_end && (r_ox == XW'(OW - 1)) && (r_oy == YW'(OH - 1));
    if (r_state != S_IDLE) w_adr = r_row_base + ADR_SIZE'(r_kx);
  end

  // Window counters; row_base tracks (oy+ky)*IMG_W + ox, win_base tracks oy*IMG_W + ox.
  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE) begin
      r_oy       <= '0;
      r_ox       <= '0;
      r_ky       <= '0;
      r_kx       <= '0;
      r_win_base <= '0;
      r_row_base <= '0;
    end else if (w_ld) begin
      if (r_kx != KW'(K - 1)) begin
        r_kx <= r_kx + KW'(1);
      end else begin
        r_kx <= '0;
        if (r_ky != KW'(K - 1)) begin
          r_ky       <= r_ky + KW'(1);
          r_row_base <= r_row_base + ADR_SIZE'(IMG_W);
        end else begin
          r_ky <= '0;
          if (r_ox != XW'(OW - 1)) begin
            r_ox       <= r_ox + XW'(1);
            r_win_base <= r_win_base + ADR_SIZE'(1);
            r_row_base <= r_win_base + ADR_SIZE'(1);
          end else begin
            r_ox <= '0;
            if (r_oy != YW'(OH - 1)) begin
              r_oy       <= r_oy + YW'(1);
              r_win_base <= r_win_base + ADR_SIZE'(K);
              r_row_base <= r_win_base + ADR_SIZE'(K);
            end else begin
              r_oy       <= '0;
              r_win_base <= '0;
              r_row_base <= '0;
            end
          end
        end
      end
    end
  end

  // Output stage: refill on the same edge a beat is taken, otherwise drop valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_last_win  <= 1'b0;
      r_last_img  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == S_DRAIN) && w_accept;
      if (w_ld) begin
        r_out_data  <= bus.bufData;
        r_out_valid <= 1'b1;
        r_last_win  <= w_win_end;
        r_last_img  <= w_img_end;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.busy       = w_busy;
  assign bus.done       = r_done;
  assign bus.bufAdr     = w_adr;
  assign bus.outData    = r_out_data;
  assign bus.outValid   = r_out_valid;
  assign bus.outLastWin = r_last_win;
  assign bus.outLastImg = r_last_img;
endmodule

// File: tb/tb_buffer_window_reader.sv
// Scoreboard bench: a default-size reader and a 4x4/K=3 reader, each checked against a
// nested-loop window model with random backpressure, restarts and a mid-pass reset.
module tb_buffer_window_reader;
  localparam int A0 = $clog2(28 * 28);
  localparam int A1 = $clog2(4 * 4);
  localparam int N0 = 24 * 24 * 25;
  localparam int N1 = 2 * 2 * 9;

  typedef struct packed {
    logic [7:0] d;
    logic       lw;
    logic       li;
  } beat_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  bit   rnd0, rnd1;
  int   total = 0;
  int   bad = 0;

  logic [7:0] mem0 [0:28*28-1];
  logic [7:0] mem1 [0:15];
  beat_t q0[$];
  beat_t q1[$];
  int    beats0 = 0, beats1 = 0;
  bit    exp_done0 = 0, exp_done1 = 0, hold0 = 0, hold1 = 0;
  beat_t held0, held1;

  buffer_window_reader_if #(.WORD_SIZE(8), .ADR_SIZE(A0)) if0 ();
  buffer_window_reader_if #(.WORD_SIZE(8), .ADR_SIZE(A1)) if1 ();

  buffer_window_reader #(.WORD_SIZE(8), .IMG_W(28), .IMG_H(28), .K(5))
    dut0 (.clk(clk), .rst(rst0), .bus(if0.master));
  buffer_window_reader #(.WORD_SIZE(8), .IMG_W(4), .IMG_H(4), .K(3))
    dut1 (.clk(clk), .rst(rst1), .bus(if1.master));

  always #5 clk = ~clk;
  assign if0.bufData = mem0[if0.bufAdr];
  assign if1.bufData = mem1[if1.bufAdr];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: every window in row-major order, element address straight from the formula.
  task automatic push_model(input int w, input int h, input int k, input bit which);
    beat_t b;
    int adr;
    for (int oy = 0; oy <= h - k; oy++)
      for (int ox = 0; ox <= w - k; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            adr  = (oy + ky) * w + ox + kx;
            b.d  = which ? mem1[adr] : mem0[adr];
            b.lw = (ky == k - 1) && (kx == k - 1);
            b.li = b.lw && (oy == h - k) && (ox == w - k);
            if (which) q1.push_back(b);
            else       q0.push_back(b);
          end
  endtask

  initial begin
    if0.outReady = 1'b1;
    if1.outReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if0.outReady = rnd0 ? 1'($urandom_range(0, 1)) : 1'b1;
      if1.outReady = rnd1 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor for the default-size reader.
  always @(negedge clk) begin
    beat_t e;
    if (rst0) begin
      exp_done0 = 0;
      hold0     = 0;
    end else begin
      chk("done0", 32'(if0.done), 32'(exp_done0));
      exp_done0 = 0;
      if (if0.done) begin
        chk("beats0", 32'(beats0), 32'(N0));
        beats0 = 0;
      end
      if (hold0)
        chk("hold0", 32'({if0.outData, if0.outLastWin, if0.outLastImg}), 32'(held0));
      if (if0.outValid && if0.outReady) begin
        beats0++;
        chk("expected0", 32'(q0.size() > 0), 32'd1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("beat0", 32'({if0.outData, if0.outLastWin, if0.outLastImg}), 32'(e));
          if (e.li) exp_done0 = 1;
        end
      end
      hold0 = if0.outValid && !if0.outReady;
      held0 = {if0.outData, if0.outLastWin, if0.outLastImg};
    end
  end

  // Monitor for the 4x4 reader.
  always @(negedge clk) begin
    beat_t e;
    if (rst1) begin
      exp_done1 = 0;
      hold1     = 0;
    end else begin
      chk("done1", 32'(if1.done), 32'(exp_done1));
      exp_done1 = 0;
      if (if1.done) begin
        chk("beats1", 32'(beats1), 32'(N1));
        beats1 = 0;
      end
      if (hold1)
        chk("hold1", 32'({if1.outData, if1.outLastWin, if1.outLastImg}), 32'(held1));
      if (if1.outValid && if1.outReady) begin
        beats1++;
        chk("expected1", 32'(q1.size() > 0), 32'd1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("beat1", 32'({if1.outData, if1.outLastWin, if1.outLastImg}), 32'(e));
          if (e.li) exp_done1 = 1;
        end
      end
      hold1 = if1.outValid && !if1.outReady;
      held1 = {if1.outData, if1.outLastWin, if1.outLastImg};
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_idle0(input string nm);
    chk(nm, 32'({if0.busy, if0.done, if0.outValid, if0.outLastWin, if0.outLastImg}), 32'd0);
    chk({nm, "_data"}, 32'(if0.outData), 32'd0);
    chk({nm, "_adr"}, 32'(if0.bufAdr), 32'd0);
  endtask

  task automatic start0();
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    chk("start0_busy", 32'(if0.busy), 32'd1);
    chk("start0_adr", 32'(if0.bufAdr), 32'd0);
    chk("start0_novalid", 32'(if0.outValid), 32'd0);
    tick();
    chk("start0_valid", 32'(if0.outValid), 32'd1);
  endtask

  task automatic wait_done0(input bit noisy);
    int n = 0;
    while (!if0.done && n < 40000) begin
      if (noisy)
        if0.start = (if0.outValid && if0.outLastImg) || ($urandom_range(0, 63) == 0);
      tick();
      n++;
    end
    if0.start = 1'b0;
    chk("timeout0", 32'(if0.done), 32'd1);
  endtask

  task automatic flow0();
    rst0 = 1'b1;
    if0.start = 1'b0;
    rnd0 = 0;
    tick();
    tick();
    chk_idle0("reset0");
    rst0 = 1'b0;
    tick();

    for (int i = 0; i < 784; i++) mem0[i] = 8'(i);
    push_model(28, 28, 5, 0);
    start0();
    wait_done0(0);
    chk("drain0_a", 32'(q0.size()), 32'd0);

    // Random data and backpressure, with starts sprinkled over STREAM and DRAIN.
    for (int i = 0; i < 784; i++) mem0[i] = 8'($urandom);
    rnd0 = 1;
    push_model(28, 28, 5, 0);
    start0();
    wait_done0(1);
    chk("drain0_b", 32'(q0.size()), 32'd0);

    // Start in the cycle done is high: identical pass follows.
    rnd0 = 0;
    push_model(28, 28, 5, 0);
    start0();
    wait_done0(0);
    chk("drain0_c", 32'(q0.size()), 32'd0);

    // Reset at beat 100 abandons the pass; a fresh start begins at address 0.
    for (int i = 0; i < 784; i++) mem0[i] = 8'(i);
    push_model(28, 28, 5, 0);
    start0();
    for (int n = 0; n < 1000 && beats0 < 100; n++) tick();
    chk("reach100", 32'(beats0 >= 100), 32'd1);
    rst0 = 1'b1;
    tick();
    chk_idle0("midreset0");
    rst0 = 1'b0;
    q0.delete();
    beats0 = 0;
    for (int n = 0; n < 4; n++) tick();
    chk_idle0("postreset0");
    push_model(28, 28, 5, 0);
    start0();
    wait_done0(0);
    chk("drain0_d", 32'(q0.size()), 32'd0);
  endtask

  task automatic flow1();
    int n = 0;
    rst1 = 1'b1;
    if1.start = 1'b0;
    rnd1 = 1;
    tick();
    tick();
    chk("reset1", 32'({if1.busy, if1.done, if1.outValid, if1.outLastWin, if1.outLastImg}), 32'd0);
    chk("reset1_adr", 32'(if1.bufAdr), 32'd0);
    rst1 = 1'b0;
    for (int i = 0; i < 16; i++) mem1[i] = 8'(i);
    push_model(4, 4, 3, 1);
    tick();
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    chk("start1_busy", 32'(if1.busy), 32'd1);
    while (!if1.done && n < 2000) begin
      tick();
      n++;
    end
    chk("timeout1", 32'(if1.done), 32'd1);
    tick();
    chk("done1_pulse", 32'({if1.done, if1.busy}), 32'd0);
    chk("drain1", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    fork
      flow0();
      flow1();
    join
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
